// File: rtl/mem_port_arb2.sv
// Two-port arbiter/sequencer for the shared single-ported 16-bit memory.
// Port 1 (memory stage) normally wins ties; port 0 (fetch) is protected by a starvation counter.
module mem_port_arb2 #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state_r;
    logic        sel_r;
    logic [3:0]  starve_cnt_r;
    logic [7:0]  wait_cnt_r;

    logic        any_req_s;
    logic        sel_next_s;
    logic        wr_next_s;
    logic [15:0] addr_next_s;
    logic [15:0] wdata_next_s;

    function automatic logic [15:0] sel16(input logic s, input logic [15:0] a0, input logic [15:0] a1);
        return s ? a1 : a0;
    endfunction

    // Arbitration and steering of the winner's command onto the shared bus.
    always_comb begin
        any_req_s = req0 | req1;
        if (req1 && !(req0 && (starve_cnt_r == STARVE_LIM))) begin
            sel_next_s = 1'b1;
        end else begin
            sel_next_s = 1'b0;
        end
        wr_next_s    = sel_next_s ? wr1 : wr0;
        addr_next_s  = sel16(sel_next_s, addr0, addr1);
        wdata_next_s = sel16(sel_next_s, wdata0, wdata1);
    end

    // Access sequencer: all outputs are registered and set one edge ahead of their cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            sel_r        <= 1'b0;
            starve_cnt_r <= 4'd0;
            wait_cnt_r   <= 8'd0;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata        <= 16'h0000;
            err          <= 1'b0;
            mem_en       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= 16'h0000;
            mem_wdata    <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        sel_r     <= sel_next_s;
                        mem_wr    <= wr_next_s;
                        mem_addr  <= addr_next_s;
                        mem_wdata <= wdata_next_s;
                        mem_en    <= 1'b1;
                        gnt0      <= ~sel_next_s;
                        gnt1      <= sel_next_s;
                        state_r   <= ISSUE;
                        // Only port-1 wins over a waiting port 0 count toward starvation.
                        if (!sel_next_s) begin
                            starve_cnt_r <= 4'd0;
                        end else if (req0 && (starve_cnt_r != STARVE_LIM)) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    mem_en     <= 1'b0;
                    gnt0       <= 1'b0;
                    gnt1       <= 1'b0;
                    wait_cnt_r <= 8'd0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        rdata   <= mem_rdata;
                        err     <= 1'b0;
                        done0   <= ~sel_r;
                        done1   <= sel_r;
                        state_r <= DONE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        rdata   <= 16'h0000;
                        err     <= 1'b1;
                        done0   <= ~sel_r;
                        done1   <= sel_r;
                        state_r <= DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    rdata     <= 16'h0000;
                    err       <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= 16'h0000;
                    mem_wdata <= 16'h0000;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb2.sv
// Bench for mem_port_arb2: a transaction-timeline model checked every cycle plus
// directed scenarios with hand-computed latencies and data.
module tb_mem_port_arb2;

    localparam int TO = 16;
    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, wr0, wr1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err, mem_en, mem_wr, mem_done;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_gnt = 0;
    int n_done = 0;
    int gq[$];

    int          mem_lat   = 1;
    logic [15:0] resp_data = 16'h0000;
    logic        stray     = 1'b0;

    // timeline model of the current access
    bit          busy = 1'b0;
    int          mp, gcyc, dcyc, starve;
    logic        mwr, merr;
    logic [15:0] maddr, mwd, mrd;

    mem_port_arb2 #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance the model by one edge; e is the number of the cycle that edge starts.
    task automatic model_step(input int e);
        int w;
        if (!rst_n) begin
            busy   = 1'b0;
            starve = 0;
        end else if (busy && dcyc >= 0 && e - 1 == dcyc) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (req0 || req1) begin
                mp = (req1 && !(req0 && starve == SM)) ? 1 : 0;
                if (mp == 0) starve = 0;
                else if (req0 && starve < SM) starve++;
                mwr   = mp ? wr1 : wr0;
                maddr = mp ? addr1 : addr0;
                mwd   = mp ? wdata1 : wdata0;
                busy  = 1'b1;
                gcyc  = e;
                dcyc  = -1;
            end
        end else if (dcyc < 0 && e - 1 > gcyc) begin
            w = e - 1 - (gcyc + 1);
            if (mem_done) begin
                dcyc = e; mrd = mem_rdata; merr = 1'b0;
            end else if (w == TO - 1) begin
                dcyc = e; mrd = 16'h0000; merr = 1'b1;
            end
        end
    endtask

    task automatic compare();
        bit en, dn;
        en = busy && cyc == gcyc;
        dn = busy && dcyc >= 0 && cyc == dcyc;
        chk("gnt0", gnt0, en && mp == 0);
        chk("gnt1", gnt1, en && mp == 1);
        chk("mem_en", mem_en, en);
        if (en) chk("mem_wr", mem_wr, mwr);
        chk("mem_addr", mem_addr, busy ? maddr : 16'h0000);
        chk("mem_wdata", mem_wdata, busy ? mwd : 16'h0000);
        chk("done0", done0, dn && mp == 0);
        chk("done1", done1, dn && mp == 1);
        chk("rdata", rdata, dn ? mrd : 16'h0000);
        chk("err", err, dn ? merr : 1'b0);
        if (gnt0) gq.push_back(0);
        if (gnt1) gq.push_back(1);
        if (gnt0 || gnt1) n_gnt++;
        if (done0 || done1) n_done++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(cyc);
            #1;
            compare();
        end
    end

    // memory responder: mem_done mem_lat cycles after mem_en (0 = never answer)
    initial begin
        int cnt;
        cnt = 0;
        mem_done = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                cnt = mem_lat;
                mem_done = stray;
            end else if (cnt > 0) begin
                cnt--;
                mem_done = (cnt == 0) || stray;
                if (cnt == 0) mem_rdata = resp_data;
            end else begin
                mem_done = stray;
            end
        end
    end

    task automatic access(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input int lat, input logic [15:0] rsp, input bit hold,
                          output int t0, output int tg, output int td,
                          output logic [15:0] rd, output logic e, output logic gwr,
                          output logic [15:0] gaddr, output logic [15:0] gwd, output bit other);
        mem_lat = lat;
        resp_data = rsp;
        @(negedge clk);
        t0 = cyc; tg = -1; td = -1; other = 1'b0;
        rd = 16'h0000; e = 1'b0; gwr = 1'b0; gaddr = 16'h0000; gwd = 16'h0000;
        if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 100 && td < 0; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) begin tg = cyc; gwr = mem_wr; gaddr = mem_addr; gwd = mem_wdata; end
            if (p ? done0 : done1) other = 1'b1;
            if (p ? done1 : done0) begin td = cyc; rd = rdata; e = err; end
        end
        chk("access_bound", td >= 0, 1'b1);
        if (hold) @(negedge clk);
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        int t0, tg, td, n0, n1;
        logic [15:0] rd, ga, gw;
        logic e, gwr;
        bit other;
        int exp_order[8];
        exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_gnt", {gnt0, gnt1, done0, done1, err}, 5'b00000);
        rst_n = 1'b1;

        // 1: port-0 read, memory answers 2 cycles after mem_en
        access(1'b0, 1'b0, 16'h1234, 16'h0000, 2, 16'hBEEF, 1'b0, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t1_gnt_lat", tg - t0, 1);
        chk("t1_done_lat", td - t0, 4);
        chk("t1_addr", ga, 16'h1234);
        chk("t1_wr", gwr, 1'b0);
        chk("t1_rdata", rd, 16'hBEEF);
        chk("t1_err", e, 1'b0);
        repeat (2) @(negedge clk);

        // 2: both ports requesting continuously
        mem_lat = 1;
        gq.delete();
        addr0 = 16'h0A00; addr1 = 16'h0B00; wr0 = 1'b0; wr1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 100 && gq.size() < 8; i++) @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        chk("t2_ngrants", gq.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < gq.size()) chk($sformatf("t2_order%0d", i), gq[i], exp_order[i]);
        repeat (6) @(negedge clk);

        // 3: port-1 write
        access(1'b1, 1'b1, 16'h00FE, 16'hA5A5, 1, 16'h1111, 1'b0, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t3_wr", gwr, 1'b1);
        chk("t3_addr", ga, 16'h00FE);
        chk("t3_wdata", gw, 16'hA5A5);
        chk("t3_done0_quiet", other, 1'b0);
        chk("t3_gnt_lat", tg - t0, 1);
        repeat (2) @(negedge clk);

        // 4: timeout, then a normal access
        access(1'b0, 1'b0, 16'h0042, 16'h0000, 0, 16'hFFFF, 1'b0, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t4_timeout_span", td - tg, 17);
        chk("t4_err", e, 1'b1);
        chk("t4_rdata", rd, 16'h0000);
        access(1'b0, 1'b0, 16'h0043, 16'h0000, 1, 16'h5A5A, 1'b0, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t4_next_err", e, 1'b0);
        chk("t4_next_rdata", rd, 16'h5A5A);
        chk("t4_next_span", td - tg, 2);
        repeat (2) @(negedge clk);

        // 5: asynchronous reset during WAIT
        mem_lat = 0;
        n1 = n_done;
        req0 = 1'b1; addr0 = 16'h0777; wr0 = 1'b0;
        for (int i = 0; i < 20 && !gnt0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t5_pre_addr", mem_addr, 16'h0777);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_addr", mem_addr, 16'h0000);
        chk("t5_async_pulses", {mem_en, gnt0, gnt1, done0, done1, err}, 6'b000000);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("t5_no_done", n_done - n1, 0);
        access(1'b1, 1'b0, 16'h0321, 16'h0000, 1, 16'h7777, 1'b0, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t5_fresh_gnt", tg - t0, 1);
        chk("t5_fresh_rdata", rd, 16'h7777);
        repeat (2) @(negedge clk);

        // 6: req0 held past done0, stray mem_done while idle
        access(1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'h2468, 1'b1, t0, tg, td, rd, e, gwr, ga, gw, other);
        chk("t6_rdata", rd, 16'h2468);
        n0 = n_gnt; n1 = n_done;
        @(posedge clk); #2 stray = 1'b1;
        @(posedge clk); #2 stray = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_no_regrant", n_gnt - n0, 0);
        chk("t6_no_done", n_done - n1, 0);
        chk("t6_idle_addr", mem_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arb2.md
Name: mem_port_arb2

Overview:
- Two-requester arbiter and sequencer for the single-ported 16-bit memory shared by the fetch stage (port 0) and the memory stage (port 1).
- Internally steers the winner's address and write data onto the shared bus with 16-bit 2:1 select logic.
- Issues one memory command at a time, waits for completion (bounded by a timeout), then returns read data and status to the winning port.

Parameters:
- TIMEOUT, 16: max WAIT cycles before the access is aborted with error; legal 2..255.
- STARVE_MAX, 3: consecutive port-1 grants made while port 0 was requesting, after which port 0 wins the next tie; legal 1..15.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  level request; held until the matching done pulse.
- wr0, wr1  in  1  1=write, 0=read; stable while req is high.
- addr0, addr1  in  16  access address; stable while req is high.
- wdata0, wdata1  in  16  write data; stable while req is high.
- gnt0, gnt1  out  1  one-cycle pulse: port's request accepted.
- done0, done1  out  1  one-cycle pulse: port's access finished.
- rdata  out  16  read data, valid only while done0 or done1 is high; 0 otherwise.
- err  out  1  high with done pulse if the access timed out.
- mem_en  out  1  one-cycle command strobe to memory.
- mem_wr  out  1  write enable, valid with mem_en.
- mem_addr  out  16  latched address; held from ISSUE until return to IDLE.
- mem_wdata  out  16  latched write data; same hold rule as mem_addr.
- mem_done  in  1  memory completion pulse.
- mem_rdata  in  16  memory read data, valid with mem_done.

Behaviour:
- Reset (asynchronous, rst_n=0): outputs are forced to 0 immediately, independent of clk.
  - state=IDLE, sel=0, starve_cnt=0, wait_cnt=0.
  - All outputs 0, including mem_en, gnt*, done*, err, rdata, mem_addr and mem_wdata.
  - Reset mid-access abandons the access; no done pulse is produced.
  - Normal operation resumes on the first rising edge after rst_n=1.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE (arbitrate):
  - Only req1: grant port 1.
  - Only req0: grant port 0.
  - Both high: port 1 wins unless starve_cnt==STARVE_MAX, in which case port 0 wins.
  - No request: stay in IDLE.
  - On grant, at the edge: latch sel, wr, addr and wdata through the 16-bit select into mem_wr, mem_addr and mem_wdata; go to ISSUE.
- ISSUE (1 cycle): mem_en=1 and gnt<sel>=1. mem_done is ignored in this cycle. Go to WAIT with wait_cnt=0.
- WAIT:
  - mem_done=1: capture mem_rdata (writes also capture it; the value is don't-care but is driven), err=0, go to DONE.
  - Otherwise wait_cnt increments.
  - wait_cnt reaches TIMEOUT-1 without mem_done: go to DONE with err=1 and rdata=0.
  - A mem_done arriving in the same cycle as the timeout takes precedence as a success.
- DONE (1 cycle):
  - done<sel>=1; rdata and err are valid.
  - Requests are not sampled, so a requester still holding req this cycle is not re-granted.
  - Next state is IDLE; mem_addr and mem_wdata clear to 0.
- Latency: a request seen in IDLE at cycle T gives gnt/mem_en at T+1. mem_done at T+1+k (k>=1) gives done at T+2+k. Minimum turnaround is 4 cycles per access.
- Starvation counter:
  - Port 1 granted while req0 high: starve_cnt increments, saturating at STARVE_MAX.
  - Port 0 granted: starve_cnt clears.
  - Port 1 granted with req0 low: starve_cnt is unchanged.
- A mem_done outside WAIT is ignored. Requests that drop before grant are simply lost; there is no error.
- gnt0/gnt1 are never high together, and neither are done0/done1.

Test Plan:
- Reset release then req0 alone, read, addr0=0x1234, mem_done 2 cycles after mem_en with mem_rdata=0xBEEF -> gnt0 at T+1 with mem_addr=0x1234 and mem_wr=0; done0=1, rdata=0xBEEF, err=0 at T+4; then IDLE.
- req0 and req1 both high continuously, mem_done 1 cycle after each mem_en, STARVE_MAX=3 -> grant order 1,1,1,0,1,1,1,0; no port-0 wait exceeds 3 consecutive port-1 grants.
- Port 1 write with addr1=0x00FE, wdata1=0xA5A5 -> mem_en with mem_wr=1, mem_addr=0x00FE, mem_wdata=0xA5A5; done1 pulse; done0 stays 0.
- Port 0 read with mem_done never asserted, TIMEOUT=16 -> done0 with err=1 and rdata=0 exactly 16 WAIT cycles after ISSUE; the next request is served normally.
- rst_n pulled low during WAIT -> mem_addr, mem_en and all pulses go to 0 immediately without a clock edge; no done pulse; after release, a fresh req1 gets gnt1 one cycle later.
- Requester keeps req0 high one cycle past done0; mem_done pulsed during IDLE -> no duplicate grant, no spurious done, state stays IDLE.
